// File: rtl/snd_req_queue.sv
// Sound request queue: buffers game sound events in a small FIFO and plays them one at a time.
// Codes 6/7 pre-empt everything. Define SNDQ_DEDUP_EN to drop a normal request matching the FIFO tail.
module snd_req_queue #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1000,
    parameter int START_TMO  = 4
) (
    input  logic       clk_1mhz,
    input  logic       rst_n,
    input  logic       ev_valid,
    input  logic [2:0] ev_code,
    input  logic       playing,
    output logic [2:0] snd_mode,
    output logic       trig,
    output logic       busy,
    output logic [3:0] q_count,
    output logic       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP, PREEMPT
    } state_t;

    typedef struct packed {
        logic       norm;
        logic       prio;
        logic [2:0] code;
    } req_t;

    state_t          state;
    req_t            req;
    logic [2:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [3:0]      count;
    logic [2:0]      prio_code;
    logic [15:0]     gap_cnt;
    logic [15:0]     tmo_cnt;
    logic            full, pop, push, drop, dup;

    always_comb begin
        req.code = ev_code;
        req.norm = ev_valid && (ev_code != 3'd0) && (ev_code <= 3'd5);
        req.prio = ev_valid && (ev_code >= 3'd6);
    end

`ifdef SNDQ_DEDUP_EN
    logic [PW-1:0] tail_idx;
    assign tail_idx = wr_ptr - PW'(1);
    assign dup      = (count != 4'd0) && (mem[tail_idx] == req.code);
`else
    assign dup = 1'b0;
`endif

    // A priority request flushes the FIFO, so it also blocks the pop in IDLE.
    assign full = (count == 4'(DEPTH));
    assign pop  = (state == IDLE) && (count != 4'd0) && !req.prio;
    assign push = req.norm && !dup && (!full || pop);
    assign drop = req.norm && !dup && full && !pop;

    assign busy    = (state != IDLE) || (count != 4'd0);
    assign q_count = count;

    always_ff @(posedge clk_1mhz) begin
        if (push)
            mem[wr_ptr] <= req.code;
    end

    always_ff @(posedge clk_1mhz) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 4'd0;
            overflow  <= 1'b0;
            prio_code <= 3'd0;
        end else if (req.prio) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 4'd0;
            prio_code <= req.code;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

    // snd_mode is written only on transitions into ISSUE; trig is the registered twin of that entry.
    always_ff @(posedge clk_1mhz) begin
        if (!rst_n) begin
            state    <= IDLE;
            snd_mode <= 3'd0;
            trig     <= 1'b0;
            gap_cnt  <= 16'd0;
            tmo_cnt  <= 16'd0;
        end else begin
            trig <= 1'b0;
            if (req.prio) begin
                state <= PREEMPT;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            snd_mode <= mem[rd_ptr];
                            trig     <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        tmo_cnt <= 16'd0;
                        state   <= WAIT_START;
                    end
                    WAIT_START: begin
                        if (playing) begin
                            state <= WAIT_DONE;
                        end else if (tmo_cnt == 16'(START_TMO - 1)) begin
                            gap_cnt <= 16'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    WAIT_DONE: begin
                        if (!playing) begin
                            gap_cnt <= 16'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 16'd0)
                            state <= IDLE;
                        else
                            gap_cnt <= gap_cnt - 16'd1;
                    end
                    PREEMPT: begin
                        snd_mode <= prio_code;
                        trig     <= 1'b1;
                        state    <= ISSUE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
